// File: rtl/tt_um_jimktrains_vslc_sequencer.sv
// VSLC program store and PLC-style scan sequencer: byte loader, register-file program memory, scan replay.
// Optional single-step control is compiled in with `define VSLC_SEQ_STEP_EN.
module tt_um_jimktrains_vslc_sequencer #(
   parameter int PROG_DEPTH = 32,
   parameter int LW         = $clog2(PROG_DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_en,
   input  logic          load_valid,
   input  logic [7:0]    load_byte,
   output logic          load_ready,
   input  logic          run_en,
   input  logic [7:0]    ui_in,
`ifdef VSLC_SEQ_STEP_EN
   input  logic          step_mode,
   input  logic          step,
`endif
   output logic [7:0]    instr,
   output logic          instr_ready,
   output logic [7:0]    ui_in_scan,
   output logic [7:0]    ui_in_prev,
   output logic [LW-1:0] prog_len,
   output logic          overflow,
   output logic          scan_done,
   output logic          busy
);

   localparam int            AW      = $clog2(PROG_DEPTH);
   localparam logic [LW-1:0] DEPTH_L = LW'(PROG_DEPTH);
   localparam logic [7:0]    END_OP  = 8'hFF;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXEC} state_t;

   state_t        state_q, state_d;
   logic [LW-1:0] wr_ptr_q, wr_ptr_d;
   logic [LW-1:0] prog_len_q, prog_len_d;
   logic [LW-1:0] pc_q, pc_d;
   logic [7:0]    instr_q, instr_d;
   logic          instr_ready_q, instr_ready_d;
   logic [7:0]    ui_in_scan_q, ui_in_scan_d;
   logic [7:0]    ui_in_prev_q, ui_in_prev_d;
   logic          overflow_q, overflow_d;
   logic          scan_done_q, scan_done_d;

   logic [7:0]    mem_q [PROG_DEPTH];
   logic          mem_we;
   logic [AW-1:0] mem_wa;
   logic [7:0]    mem_rd;
   logic          full;
   logic          scan_end;
   logic          advance;

   assign full     = (wr_ptr_q >= DEPTH_L);
   // pc only reaches PROG_DEPTH when it also equals prog_len, so the wrapped read is masked.
   assign mem_rd   = mem_q[pc_q[AW-1:0]];
   assign scan_end = (pc_q == prog_len_q) || (mem_rd == END_OP);

`ifdef VSLC_SEQ_STEP_EN
   assign advance  = !step_mode || step;
`else
   assign advance  = 1'b1;
`endif

   always_comb begin
      state_d       = state_q;
      wr_ptr_d      = wr_ptr_q;
      prog_len_d    = prog_len_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_ready_d = 1'b0;
      ui_in_scan_d  = ui_in_scan_q;
      ui_in_prev_d  = ui_in_prev_q;
      overflow_d    = overflow_q;
      scan_done_d   = 1'b0;
      mem_we        = 1'b0;
      mem_wa        = wr_ptr_q[AW-1:0];

      if (load_en && state_q != S_LOAD) begin
         state_d    = S_LOAD;
         wr_ptr_d   = '0;
         prog_len_d = '0;
         overflow_d = 1'b0;
      end else begin
         case (state_q)
            S_LOAD: begin
               if (load_valid) begin
                  if (!full) begin
                     mem_we     = 1'b1;
                     wr_ptr_d   = wr_ptr_q + LW'(1);
                     prog_len_d = prog_len_q + LW'(1);
                  end else begin
                     overflow_d = 1'b1;
                  end
               end
               if (!load_en) state_d = S_IDLE;
            end
            S_IDLE: begin
               // Both images start equal so the first scan sees no edges.
               if (run_en && prog_len_q != '0) begin
                  state_d      = S_EXEC;
                  ui_in_scan_d = ui_in;
                  ui_in_prev_d = ui_in;
                  pc_d         = '0;
               end
            end
            S_EXEC: begin
               if (!run_en) begin
                  state_d = S_IDLE;
               end else if (advance) begin
                  if (scan_end) begin
                     ui_in_prev_d = ui_in_scan_q;
                     ui_in_scan_d = ui_in;
                     pc_d         = '0;
                     scan_done_d  = 1'b1;
                  end else begin
                     instr_d       = mem_rd;
                     instr_ready_d = 1'b1;
                     pc_d          = pc_q + LW'(1);
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         wr_ptr_q      <= '0;
         prog_len_q    <= '0;
         pc_q          <= '0;
         instr_q       <= '0;
         instr_ready_q <= 1'b0;
         ui_in_scan_q  <= '0;
         ui_in_prev_q  <= '0;
         overflow_q    <= 1'b0;
         scan_done_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         prog_len_q    <= prog_len_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_ready_q <= instr_ready_d;
         ui_in_scan_q  <= ui_in_scan_d;
         ui_in_prev_q  <= ui_in_prev_d;
         overflow_q    <= overflow_d;
         scan_done_q   <= scan_done_d;
      end
   end

   // Program memory is left unreset; prog_len gates what is reachable.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[mem_wa] <= load_byte;
   end

   assign load_ready  = (state_q == S_LOAD) && !full;
   assign busy        = (state_q == S_EXEC);
   assign instr       = instr_q;
   assign instr_ready = instr_ready_q;
   assign ui_in_scan  = ui_in_scan_q;
   assign ui_in_prev  = ui_in_prev_q;
   assign prog_len    = prog_len_q;
   assign overflow    = overflow_q;
   assign scan_done   = scan_done_q;

endmodule

// File: tb/tb_tt_um_jimktrains_vslc_sequencer.sv
// Bench for the VSLC sequencer: directed vector table, corner sequences and a randomized scan model.
module tb_tt_um_jimktrains_vslc_sequencer;
   localparam int DEPTH = 32;
   localparam int LW    = 6;

   logic          clk = 1'b0, rst_n = 1'b0;
   logic          load_en = 1'b0, load_valid = 1'b0, run_en = 1'b0;
   logic [7:0]    load_byte = 8'h00, ui = 8'h00;
`ifdef VSLC_SEQ_STEP_EN
   logic          step_mode = 1'b0, step = 1'b0;
`endif
   logic          load_ready, instr_ready, overflow, scan_done, busy;
   logic [7:0]    instr, ui_in_scan, ui_in_prev;
   logic [LW-1:0] prog_len;

   tt_um_jimktrains_vslc_sequencer #(.PROG_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .load_en(load_en), .load_valid(load_valid), .load_byte(load_byte), .load_ready(load_ready),
      .run_en(run_en), .ui_in(ui),
`ifdef VSLC_SEQ_STEP_EN
      .step_mode(step_mode), .step(step),
`endif
      .instr(instr), .instr_ready(instr_ready), .ui_in_scan(ui_in_scan), .ui_in_prev(ui_in_prev),
      .prog_len(prog_len), .overflow(overflow), .scan_done(scan_done), .busy(busy)
   );

   always #5 clk = ~clk;

   int         total = 0, bad = 0;
   logic [7:0] prog [64];
   int         plen = 0;
   logic [7:0] exp_instr = 8'h00, exp_scan = 8'h00, exp_prev = 8'h00;

   typedef struct packed {
      logic le, lv; logic [7:0] lb; logic run; logic [7:0] ui;
      logic lr, ir; logic [7:0] ins; logic sd; logic [5:0] pl; logic bz, ov; logic [7:0] sc, pv;
   } vec_t;
   vec_t tbl [15];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".lr"}, load_ready, 0);  chk({tag, ".ir"}, instr_ready, 0);
      chk({tag, ".ins"}, instr, 0);      chk({tag, ".sc"}, ui_in_scan, 0);
      chk({tag, ".pv"}, ui_in_prev, 0);  chk({tag, ".pl"}, prog_len, 0);
      chk({tag, ".ov"}, overflow, 0);    chk({tag, ".sd"}, scan_done, 0);
      chk({tag, ".bz"}, busy, 0);
   endtask

   task automatic load_prog(input int n);
      load_en = 1'b1; load_valid = 1'b0; run_en = 1'b0;
      tick();
      chk("ld.enter_lr", load_ready, 1); chk("ld.enter_pl", prog_len, 0); chk("ld.enter_ov", overflow, 0);
      for (int i = 0; i < n; i++) begin
         load_valid = 1'b1; load_byte = prog[i];
         tick();
         chk($sformatf("ld%0d.pl", i), prog_len, (i + 1 < DEPTH) ? i + 1 : DEPTH);
         chk($sformatf("ld%0d.lr", i), load_ready, (i + 1 < DEPTH) ? 1 : 0);
         chk($sformatf("ld%0d.ov", i), overflow, (i >= DEPTH) ? 1 : 0);
      end
      load_valid = 1'b0; load_en = 1'b0;
      tick();
      chk("ld.exit_lr", load_ready, 0); chk("ld.exit_bz", busy, 0);
      plen = (n < DEPTH) ? n : DEPTH;
   endtask

   // Scan model: the issue stream is the program up to the first END marker (or prog_len),
   // followed by one boundary slot, repeating; a boundary rolls the input images.
   task automatic run_check(input int cycles, input bit rnd, input int step_every, output int sds);
      int  n, ev, j;
      bit  adv, e_ir, e_sd;
      n = plen;
      for (int i = 0; i < plen; i++) if (prog[i] == 8'hFF) begin n = i; break; end
      ev = 0; sds = 0;
      load_en = 1'b0; run_en = 1'b1;
      tick();
      exp_scan = ui; exp_prev = ui;
      chk("run.start_bz", busy, 1); chk("run.start_ir", instr_ready, 0);
      chk("run.start_sc", ui_in_scan, exp_scan); chk("run.start_pv", ui_in_prev, exp_prev);
      for (int k = 1; k <= cycles; k++) begin
         if (rnd) ui = 8'($urandom);
         adv = 1'b1;
`ifdef VSLC_SEQ_STEP_EN
         step_mode = (step_every > 0);
         step      = (step_every > 0) && (k % step_every == 0);
         if (step_every > 0) adv = step;
`endif
         tick();
         e_ir = 1'b0; e_sd = 1'b0;
         if (adv) begin
            j = ev % (n + 1); ev++;
            if (j < n) begin e_ir = 1'b1; exp_instr = prog[j]; end
            else begin e_sd = 1'b1; exp_prev = exp_scan; exp_scan = ui; end
         end
         if (scan_done) sds++;
         chk($sformatf("run%0d.ir", k), instr_ready, e_ir);
         chk($sformatf("run%0d.sd", k), scan_done, e_sd);
         chk($sformatf("run%0d.ins", k), instr, exp_instr);
         chk($sformatf("run%0d.sc", k), ui_in_scan, exp_scan);
         chk($sformatf("run%0d.pv", k), ui_in_prev, exp_prev);
         chk($sformatf("run%0d.bz", k), busy, 1);
         chk($sformatf("run%0d.pl", k), prog_len, plen);
      end
      run_en = 1'b0;
`ifdef VSLC_SEQ_STEP_EN
      step_mode = 1'b0; step = 1'b0;
`endif
      tick();
      chk("run.stop_bz", busy, 0); chk("run.stop_ir", instr_ready, 0); chk("run.stop_ins", instr, exp_instr);
   endtask

   initial begin
      int cnt;
      //        le    lv    lb     run   ui     lr    ir    ins    sd    pl    bz    ov    sc     pv
      tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 6'd0, 1'b0, 1'b0, 8'h00, 8'h00};
      tbl[1]  = '{1'b1, 1'b1, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 6'd1, 1'b0, 1'b0, 8'h00, 8'h00};
      tbl[2]  = '{1'b1, 1'b1, 8'h02, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 6'd2, 1'b0, 1'b0, 8'h00, 8'h00};
      tbl[3]  = '{1'b1, 1'b1, 8'h84, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 6'd3, 1'b0, 1'b0, 8'h00, 8'h00};
      tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 6'd3, 1'b0, 1'b0, 8'h00, 8'h00};
      tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 6'd3, 1'b1, 1'b0, 8'h00, 8'h00};
      tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 6'd3, 1'b1, 1'b0, 8'h00, 8'h00};
      tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 1'b1, 8'h02, 1'b0, 6'd3, 1'b1, 1'b0, 8'h00, 8'h00};
      tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 1'b1, 8'h84, 1'b0, 6'd3, 1'b1, 1'b0, 8'h00, 8'h00};
      tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 8'h84, 1'b1, 6'd3, 1'b1, 1'b0, 8'h01, 8'h00};
      tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 1'b1, 8'h01, 1'b0, 6'd3, 1'b1, 1'b0, 8'h01, 8'h00};
      tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 1'b1, 8'h02, 1'b0, 6'd3, 1'b1, 1'b0, 8'h01, 8'h00};
      tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 1'b1, 8'h84, 1'b0, 6'd3, 1'b1, 1'b0, 8'h01, 8'h00};
      tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 8'h84, 1'b1, 6'd3, 1'b1, 1'b0, 8'h01, 8'h01};
      tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0, 8'h84, 1'b0, 6'd3, 1'b0, 1'b0, 8'h01, 8'h01};

      #2 chk_zero("rst_hold");
      @(negedge clk) rst_n = 1'b1;
      tick();
      chk_zero("rst_rel");

      for (int i = 0; i < 15; i++) begin
         load_en = tbl[i].le; load_valid = tbl[i].lv; load_byte = tbl[i].lb;
         run_en = tbl[i].run; ui = tbl[i].ui;
         tick();
         chk($sformatf("tbl%0d.lr", i), load_ready, tbl[i].lr);
         chk($sformatf("tbl%0d.ir", i), instr_ready, tbl[i].ir);
         chk($sformatf("tbl%0d.ins", i), instr, tbl[i].ins);
         chk($sformatf("tbl%0d.sd", i), scan_done, tbl[i].sd);
         chk($sformatf("tbl%0d.pl", i), prog_len, tbl[i].pl);
         chk($sformatf("tbl%0d.bz", i), busy, tbl[i].bz);
         chk($sformatf("tbl%0d.ov", i), overflow, tbl[i].ov);
         chk($sformatf("tbl%0d.sc", i), ui_in_scan, tbl[i].sc);
         chk($sformatf("tbl%0d.pv", i), ui_in_prev, tbl[i].pv);
      end
      exp_instr = 8'h84;

      // END marker truncates the scan to one issue plus the boundary.
      prog[0] = 8'h10; prog[1] = 8'hFF; prog[2] = 8'h20;
      load_prog(3);
      run_check(6, 1'b0, 0, cnt);
      chk("ff.sd_count", cnt, 3);

      // 33 bytes into a 32-byte store.
      for (int i = 0; i < 33; i++) prog[i] = 8'(i + 1);
      load_prog(33);
      chk("ovf.flag", overflow, 1); chk("ovf.pl", prog_len, DEPTH);
      load_en = 1'b1;
      tick();
      chk("ovf.clr", overflow, 0); chk("ovf.clr_pl", prog_len, 0);
      load_en = 1'b0;
      tick();
      run_en = 1'b1;
      tick();
      chk("empty.no_run", busy, 0);
      run_en = 1'b0;
      tick();

      // load_en abandons a scan in progress.
      prog[0] = 8'h01; prog[1] = 8'h02; prog[2] = 8'h84;
      load_prog(3);
      run_en = 1'b1;
      tick(); tick(); tick();
      chk("mid.pre_ins", instr, 8'h02);
      load_en = 1'b1;
      tick();
      chk("mid.ir", instr_ready, 0); chk("mid.pl", prog_len, 0);
      chk("mid.bz", busy, 0); chk("mid.lr", load_ready, 1); chk("mid.ins", instr, 8'h02);
      load_en = 1'b0; run_en = 1'b0;
      tick();
      exp_instr = 8'h02;

      for (int t = 0; t < 6; t++) begin
         int len;
         len = $urandom_range(1, DEPTH);
         for (int i = 0; i < len; i++) prog[i] = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom);
         load_prog(len);
         run_check($urandom_range(10, 80), 1'b1, 0, cnt);
      end

`ifdef VSLC_SEQ_STEP_EN
      prog[0] = 8'h01; prog[1] = 8'h02; prog[2] = 8'h84;
      load_prog(3);
      run_check(24, 1'b0, 3, cnt);
      chk("step.sd_count", cnt, 2);
`endif

      // Asynchronous reset in the middle of a scan.
      prog[0] = 8'h01; prog[1] = 8'h02; prog[2] = 8'h84;
      load_prog(3);
      run_en = 1'b1; ui = 8'h5A;
      tick(); tick(); tick();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk_zero("arst");
      @(negedge clk);
      run_en = 1'b0; rst_n = 1'b1;
      tick();
      chk_zero("arst_rel");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
